// File: rtl/hex_rate_counter_pkg.sv
// -----------------------------------------------------------------------------
// hex_rate_counter_pkg
//
// Shared definitions for the hex rate counter slice.
//   speed_e        : encodings of the SpeedSel rate-select input
//   period_clocks  : returns the count period P, in clocks, for a rate select
//                    given the board clock frequency in Hz
// -----------------------------------------------------------------------------
package hex_rate_counter_pkg;

    typedef enum logic [1:0] {
        SPEED_FAST    = 2'b00,  // one count per enabled clock
        SPEED_1HZ     = 2'b01,  // one count per second
        SPEED_HALF    = 2'b10,  // one count every two seconds
        SPEED_QUARTER = 2'b11   // one count every four seconds
    } speed_e;

    // Period P in clocks for each rate select. The slowest setting is
    // 4*clk_freq, which is what sizes the divider's down-counter.
    function automatic int unsigned period_clocks(input logic [1:0] sel,
                                                  input int unsigned clk_freq);
        int unsigned p;
        case (speed_e'(sel))
            SPEED_FAST: p = 1;
            SPEED_1HZ:  p = clk_freq;
            SPEED_HALF: p = 2 * clk_freq;
            default:    p = 4 * clk_freq;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hex_rate_counter_rate_divider.sv
// -----------------------------------------------------------------------------
// rate_divider
//
// Down-counting rate divider. Emits Pulse on every enabled cycle in which the
// counter has reached zero; the counter then reloads to Period-1, so pulses
// are spaced exactly Period enabled cycles apart. While Enable is low the
// counter is frozen, preserving the phase across a pause.
//
// Ports
//   Clock   : system clock, rising edge
//   Reset   : asynchronous active-high reset, clears the counter to zero
//   Enable  : 1 = advance the divider, 0 = hold
//   Reload  : restart the period (load Period-1) regardless of Enable
//   Period  : period in clocks; must be at least 1
//   Pulse   : high when the counter is zero and Enable is high
// -----------------------------------------------------------------------------
module rate_divider #(
    parameter int WIDTH = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Reload,
    input  logic [WIDTH:0]   Period,
    output logic             Pulse
);

    logic [WIDTH-1:0] rate_count;
    logic [WIDTH-1:0] reload_value;

    // Period can be a power of two one bit wider than the counter; Period-1
    // always fits in WIDTH bits.
    assign reload_value = WIDTH'(Period - (WIDTH + 1)'(1));

    assign Pulse = Enable & (rate_count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rate_count <= '0;
        end else if (Reload) begin
            rate_count <= reload_value;
        end else if (Enable) begin
            if (rate_count == '0) begin
                rate_count <= reload_value;
            end else begin
                rate_count <= rate_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_rate_counter.sv
// -----------------------------------------------------------------------------
// hex_rate_counter
//
// Multi-digit hex counter for driving a row of 7-segment decoders. Digit k of
// the count is Value[4k+3:4k]; the whole count is one binary register, so
// digit carries ripple naturally.
//
// Ports
//   Clock    : system clock, all state changes on the rising edge
//   Reset    : asynchronous active-high reset
//   Enable   : 1 = count at the selected rate, 0 = pause with all state held
//   SpeedSel : rate select (see hex_rate_counter_pkg::speed_e)
//   UpDown   : 1 = increment, 0 = decrement; sampled on Tick edges only
//   Load     : synchronous parallel load strobe, works regardless of Enable
//   Data     : parallel load value
//   Value    : current count (the register itself, no output latency)
//   Tick     : high in the cycle whose closing edge steps Value
//   Wrap     : high with Tick when that step wraps (all-F->0 or 0->all-F)
//
// Per-edge priority: Reset, Load, rate change, pause, Tick, divider step.
// -----------------------------------------------------------------------------
module hex_rate_counter
    import hex_rate_counter_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [1:0]              SpeedSel,
    input  logic                    UpDown,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Data,
    output logic [4*NUM_DIGITS-1:0] Value,
    output logic                    Tick,
    output logic                    Wrap
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(4 * CLK_FREQ);

    logic [1:0]  speed_prev;
    logic        speed_change;
    logic        reload;
    logic        pulse;
    logic [CW:0] period;

    // A change of rate select restarts the period at the new rate instead of
    // finishing the old one, so a slow->fast switch takes effect promptly.
    assign speed_change = (SpeedSel != speed_prev);
    assign reload       = Load | speed_change;
    assign period       = (CW + 1)'(period_clocks(SpeedSel, CLK_FREQ));

    rate_divider #(
        .WIDTH (CW)
    ) u_rate_divider (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .Reload (reload),
        .Period (period),
        .Pulse  (pulse)
    );

    // The divider's pulse only becomes a count when nothing of higher
    // priority owns this edge; Reset is gated in so outputs stay quiet
    // while the divider sits at zero during reset.
    assign Tick = pulse & ~Load & ~speed_change & ~Reset;

    // Carry out of the top bit on increment, borrow on decrement.
    assign Wrap = Tick & (UpDown ? (&Value) : ~(|Value));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Value      <= '0;
            speed_prev <= SPEED_FAST;
        end else begin
            speed_prev <= SpeedSel;
            if (Load) begin
                Value <= Data;
            end else if (Tick) begin
                Value <= UpDown ? Value + VW'(1) : Value - VW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hex_rate_counter.sv
module tb_hex_rate_counter;

    localparam int CLK_FREQ   = 8;
    localparam int NUM_DIGITS = 2;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Enable;
    logic [1:0] SpeedSel;
    logic       UpDown;
    logic       Load;
    logic [7:0] Data;
    logic [7:0] Value;
    logic       Tick;
    logic       Wrap;

    int passed = 0;
    int total  = 0;

    hex_rate_counter #(
        .CLK_FREQ   (CLK_FREQ),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .SpeedSel (SpeedSel),
        .UpDown   (UpDown),
        .Load     (Load),
        .Data     (Data),
        .Value    (Value),
        .Tick     (Tick),
        .Wrap     (Wrap)
    );

    always #5 Clock = ~Clock;

    // Advance one clock: sample the combinational outputs mid-cycle (after the
    // falling edge), then return 1 time unit after the rising edge so the
    // caller can read the updated Value and set inputs for the next cycle.
    task automatic run_cycle(output logic t, output logic w);
        @(negedge Clock);
        #1;
        t = Tick;
        w = Wrap;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        Enable   = 1'b1;
        SpeedSel = 2'b00;
        UpDown   = 1'b1;
        Load     = 1'b0;
        Data     = 8'h00;
        #12;
        total++;
        if (Value !== 8'h00) $display("FAIL reset_value: got %h want 00", Value);
        else passed++;
        total++;
        if (Tick !== 1'b0) $display("FAIL reset_tick_gated: got %b want 0", Tick);
        else passed++;
        total++;
        if (Wrap !== 1'b0) $display("FAIL reset_wrap_gated: got %b want 0", Wrap);
        else passed++;
    endtask

    // 1 Hz rate straight out of reset: first edge is a rate change (reset
    // leaves the previous select at 00), so counts land on edges 9 and 17.
    task automatic test_rate_1hz();
        logic t, w;
        logic [7:0] exp_v;
        SpeedSel = 2'b01;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            run_cycle(t, w);
            exp_v = (i >= 17) ? 8'h02 : (i >= 9) ? 8'h01 : 8'h00;
            total++;
            if (t !== ((i == 9) || (i == 17)))
                $display("FAIL rate_1hz_tick cycle %0d: got %b want %b", i, t, (i == 9) || (i == 17));
            else passed++;
            total++;
            if (w !== 1'b0) $display("FAIL rate_1hz_wrap cycle %0d: got %b want 0", i, w);
            else passed++;
            total++;
            if (Value !== exp_v) $display("FAIL rate_1hz_value cycle %0d: got %h want %h", i, Value, exp_v);
            else passed++;
        end
    endtask

    task automatic test_wrap_up();
        logic t, w;
        logic [7:0] exp_v [4];
        logic       exp_t [4];
        logic       exp_w [4];
        exp_v = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_t = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
        SpeedSel = 2'b00;
        UpDown   = 1'b1;
        Load     = 1'b1;
        Data     = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            run_cycle(t, w);
            Load = 1'b0;
            total++;
            if (t !== exp_t[i]) $display("FAIL wrap_up_tick step %0d: got %b want %b", i, t, exp_t[i]);
            else passed++;
            total++;
            if (w !== exp_w[i]) $display("FAIL wrap_up_wrap step %0d: got %b want %b", i, w, exp_w[i]);
            else passed++;
            total++;
            if (Value !== exp_v[i]) $display("FAIL wrap_up_value step %0d: got %h want %h", i, Value, exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_down_half();
        logic t, w;
        logic [7:0] exp_v;
        SpeedSel = 2'b10;
        UpDown   = 1'b0;
        Load     = 1'b1;
        Data     = 8'h00;
        run_cycle(t, w);
        Load = 1'b0;
        total++;
        if ((t !== 1'b0) || (Value !== 8'h00))
            $display("FAIL down_half_load: got tick %b value %h want tick 0 value 00", t, Value);
        else passed++;
        for (int k = 1; k <= 32; k++) begin
            run_cycle(t, w);
            exp_v = (k >= 32) ? 8'hFE : (k >= 16) ? 8'hFF : 8'h00;
            total++;
            if (t !== ((k == 16) || (k == 32)))
                $display("FAIL down_half_tick cycle %0d: got %b want %b", k, t, (k == 16) || (k == 32));
            else passed++;
            total++;
            if (w !== (k == 16)) $display("FAIL down_half_wrap cycle %0d: got %b want %b", k, w, k == 16);
            else passed++;
            total++;
            if (Value !== exp_v) $display("FAIL down_half_value cycle %0d: got %h want %h", k, Value, exp_v);
            else passed++;
        end
    endtask

    // Pause at RateCount=3; flip direction while paused (takes effect at the
    // next count); the count resumes 4 enabled cycles later.
    task automatic test_pause();
        logic t, w;
        SpeedSel = 2'b01;
        UpDown   = 1'b1;
        Load     = 1'b1;
        Data     = 8'h10;
        run_cycle(t, w);
        Load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_cycle(t, w);
            total++;
            if ((t !== 1'b0) || (Value !== 8'h10))
                $display("FAIL pause_prerun cycle %0d: got tick %b value %h want tick 0 value 10", k, t, Value);
            else passed++;
        end
        Enable = 1'b0;
        UpDown = 1'b0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(t, w);
            total++;
            if ((t !== 1'b0) || (Value !== 8'h10))
                $display("FAIL pause_hold cycle %0d: got tick %b value %h want tick 0 value 10", k, t, Value);
            else passed++;
        end
        Enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            run_cycle(t, w);
            total++;
            if (t !== (k == 4)) $display("FAIL pause_resume_tick cycle %0d: got %b want %b", k, t, k == 4);
            else passed++;
            total++;
            if (Value !== ((k == 4) ? 8'h0F : 8'h10))
                $display("FAIL pause_resume_value cycle %0d: got %h want %h", k, Value, (k == 4) ? 8'h0F : 8'h10);
            else passed++;
        end
    endtask

    task automatic test_speed_change_and_load();
        logic t, w;
        UpDown   = 1'b1;
        SpeedSel = 2'b01;
        Load     = 1'b1;
        Data     = 8'h20;
        run_cycle(t, w);
        Load = 1'b0;
        for (int k = 0; k < 3; k++) run_cycle(t, w);
        SpeedSel = 2'b11;
        run_cycle(t, w);
        total++;
        if ((t !== 1'b0) || (Value !== 8'h20))
            $display("FAIL speed_change_edge: got tick %b value %h want tick 0 value 20", t, Value);
        else passed++;
        for (int k = 1; k <= 32; k++) begin
            run_cycle(t, w);
            total++;
            if (t !== (k == 32)) $display("FAIL speed_change_tick cycle %0d: got %b want %b", k, t, k == 32);
            else passed++;
            total++;
            if (Value !== ((k == 32) ? 8'h21 : 8'h20))
                $display("FAIL speed_change_value cycle %0d: got %h want %h", k, Value, (k == 32) ? 8'h21 : 8'h20);
            else passed++;
        end
        for (int k = 0; k < 31; k++) begin
            run_cycle(t, w);
            total++;
            if (t !== 1'b0) $display("FAIL speed_quarter_gap cycle %0d: got %b want 0", k, t);
            else passed++;
        end
        // The divider is at zero here: a count is due, but Load takes the edge.
        Load = 1'b1;
        Data = 8'h77;
        run_cycle(t, w);
        Load = 1'b0;
        total++;
        if ((t !== 1'b0) || (Value !== 8'h77))
            $display("FAIL load_over_tick: got tick %b value %h want tick 0 value 77", t, Value);
        else passed++;
        run_cycle(t, w);
        total++;
        if ((t !== 1'b0) || (Value !== 8'h77))
            $display("FAIL load_restarts_period: got tick %b value %h want tick 0 value 77", t, Value);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic t, w;
        SpeedSel = 2'b00;
        UpDown   = 1'b1;
        Load     = 1'b1;
        Data     = 8'h5A;
        run_cycle(t, w);
        Load = 1'b0;
        total++;
        if (Value !== 8'h5A) $display("FAIL async_reset_setup: got %h want 5a", Value);
        else passed++;
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if (Value !== 8'h00) $display("FAIL async_reset_value: got %h want 00", Value);
        else passed++;
        total++;
        if ((Tick !== 1'b0) || (Wrap !== 1'b0))
            $display("FAIL async_reset_outputs: got tick %b wrap %b want 0 0", Tick, Wrap);
        else passed++;
        run_cycle(t, w);
        total++;
        if ((t !== 1'b0) || (Value !== 8'h00))
            $display("FAIL async_reset_held: got tick %b value %h want tick 0 value 00", t, Value);
        else passed++;
        Reset = 1'b0;
        run_cycle(t, w);
        total++;
        if ((t !== 1'b1) || (Value !== 8'h01))
            $display("FAIL async_reset_resume: got tick %b value %h want tick 1 value 01", t, Value);
        else passed++;
    endtask

    // Random stimulus against a behavioural model: wait_left is the number of
    // enabled cycles still to pass before a count is due; any restart of the
    // period sets it to P-1.
    task automatic test_random();
        logic t, w;
        int   m_value, wait_left, prev_sel, p;
        bit   change, exp_t, exp_w;
        Reset    = 1'b1;
        Load     = 1'b0;
        Enable   = 1'b1;
        SpeedSel = 2'b00;
        UpDown   = 1'b1;
        run_cycle(t, w);
        Reset     = 1'b0;
        m_value   = 0;
        wait_left = 0;
        prev_sel  = 0;
        for (int n = 0; n < 700; n++) begin
            Enable = ($urandom_range(0, 99) < 85);
            Load   = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 3))
                0:       Data = 8'hFF;
                1:       Data = 8'h00;
                default: Data = 8'($urandom);
            endcase
            if ($urandom_range(0, 99) < 4) SpeedSel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 10) UpDown = 1'($urandom_range(0, 1));

            p      = (SpeedSel == 2'd0) ? 1 : CLK_FREQ * (1 << (int'(SpeedSel) - 1));
            change = (int'(SpeedSel) != prev_sel);
            exp_t  = Enable && !Load && !change && (wait_left == 0);
            exp_w  = exp_t && (UpDown ? (m_value == 255) : (m_value == 0));

            run_cycle(t, w);
            total++;
            if (t !== exp_t) $display("FAIL random_tick cycle %0d: got %b want %b", n, t, exp_t);
            else passed++;
            total++;
            if (w !== exp_w) $display("FAIL random_wrap cycle %0d: got %b want %b", n, w, exp_w);
            else passed++;

            if (Load) begin
                m_value   = int'(Data);
                wait_left = p - 1;
            end else if (change) begin
                wait_left = p - 1;
            end else if (Enable) begin
                if (exp_t) begin
                    m_value   = (m_value + (UpDown ? 1 : 255)) % 256;
                    wait_left = p - 1;
                end else begin
                    wait_left = wait_left - 1;
                end
            end
            prev_sel = int'(SpeedSel);

            total++;
            if (Value !== 8'(m_value)) $display("FAIL random_value cycle %0d: got %h want %h", n, Value, 8'(m_value));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_rate_1hz();
        test_wrap_up();
        test_down_half();
        test_pause();
        test_speed_change_and_load();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
